uart_word_receiver: RTL and testbench
=====================================

UART_WORD_RECEIVER -- requirements
Module: uart_word_receiver

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, line baud rate; BPS_CNT = CLK_FREQ/UART_BPS (integer divide, 434 at defaults).
REQ-003 sys_clk  input  1  single clock, all logic on rising edge.
REQ-004 sys_rst  input  1  reset, synchronous, active-high.
REQ-005 uart_rxd  input  1  asynchronous serial line, idle high.
REQ-006 recv_byte_data  output  8  last correctly received byte.
REQ-007 recv_byte_done  output  1  one-cycle strobe, byte valid.
REQ-008 recv_4bytes_data  output  32  last assembled word.
REQ-009 recv_4bytes_done  output  1  level, high while a complete word is held.
REQ-010 recv_4bytes_done_posedge  output  1  one-cycle strobe on each rising edge of recv_4bytes_done.

Function
REQ-011 uart_rxd SHALL pass through a 2-flop synchronizer; a third flop SHALL provide falling-edge detection.
REQ-012 Idle-state falling edge on the synchronized line SHALL start a frame; the baud counter counts 0..BPS_CNT-1 per bit and wraps.
REQ-013 Each bit SHALL be sampled when the baud counter equals BPS_CNT/2 (mid-bit).
REQ-014 If the start bit samples high at mid-bit, the frame SHALL be aborted and the receiver returns to idle with no strobe (glitch rejection).
REQ-015 Data bits SHALL be received LSB first, 8 bits, one stop bit, no parity.
REQ-016 At stop-bit mid sample: if high, recv_byte_data SHALL update and recv_byte_done SHALL pulse for exactly one cycle on the next clock; if low (framing error), the byte SHALL be discarded, no strobe.
REQ-017 After the stop-bit sample the receiver SHALL be idle and accept a new start edge immediately (no wait for full stop-bit end).
REQ-018 Packing: byte index counter 0..3; byte k SHALL be written to recv_4bytes_data[8k+7:8k] (first byte to [7:0], little-endian).
REQ-019 On the strobe of byte index 3, recv_4bytes_data SHALL hold all four bytes and recv_4bytes_done SHALL rise in the following cycle; byte index wraps to 0.
REQ-020 recv_4bytes_done SHALL stay high until the next recv_byte_done (first byte of the next word), then clear in that cycle.
REQ-021 Bytes of a word not yet complete SHALL be written into recv_4bytes_data as they arrive (partial word visible while done is low).
REQ-022 recv_4bytes_done_posedge SHALL equal recv_4bytes_done AND NOT its value registered one cycle earlier, registered so it is high exactly one cycle, one cycle after recv_4bytes_done rises.
REQ-023 Back-to-back words SHALL each yield exactly one recv_4bytes_done_posedge strobe; no byte is lost at full line rate.

Reset
REQ-024 While sys_rst is high at a clock edge: all outputs 0, synchronizer flops 1 (idle), receiver idle, baud and bit counters 0, byte index 0, edge-detector history 0.
REQ-025 Reset mid-frame SHALL discard the partial byte and partial word; the first byte after reset is byte index 0.

Structure
REQ-026 A shared package SHALL hold CLK_FREQ/UART_BPS defaults and the BPS_CNT derivation function.
REQ-027 The rising-edge detector SHALL be one sub-module, posedge_capturer (ports sys_clk, sys_rst, signal, signal_posedge), reused by other blocks; byte receiver and packer stay in the top.

Verification
REQ-028 Reset, then send byte 0xA5 at 115200 baud -> one recv_byte_done pulse, recv_byte_data=0xA5, recv_4bytes_done stays 0.
REQ-029 Send 0x78,0x56,0x34,0x12 -> recv_4bytes_data=0x12345678, recv_4bytes_done high, exactly one recv_4bytes_done_posedge one cycle after the rise.
REQ-030 Start-bit glitch of 100 cycles low on uart_rxd -> no recv_byte_done, byte index unchanged.
REQ-031 Frame with stop bit forced low (data 0x3C) -> no strobe, recv_byte_data retains previous value.
REQ-032 Two consecutive words 0x11223344 then 0xDEADBEEF back-to-back -> two posedge strobes, recv_4bytes_done clears on first byte of second word, final data 0xDEADBEEF.
REQ-033 Assert sys_rst after two bytes of a word, then send four bytes 0x01,0x02,0x03,0x04 -> recv_4bytes_data=0x04030201, single strobe.

Source files
------------

// File: rtl/uart_word_receiver_pkg.sv
// Shared definitions for the UART word receiver and related blocks.
//   CLK_FREQ_DEFAULT / UART_BPS_DEFAULT : default system clock and line rate
//   rx_state_t                          : byte receiver states
//   calc_bps_cnt()                      : clock cycles per UART bit
package uart_word_receiver_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 50_000_000;
  localparam int unsigned UART_BPS_DEFAULT = 115200;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Integer divide; 434 at the defaults.
  function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                               input int unsigned uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_word_receiver_if.sv
// Result bus of the UART word receiver.
//   recv_byte_data           : last correctly received byte
//   recv_byte_done           : one-cycle strobe, byte valid
//   recv_4bytes_data         : last assembled (or partially assembled) word
//   recv_4bytes_done         : high while a complete word is held
//   recv_4bytes_done_posedge : one-cycle strobe after recv_4bytes_done rises
// master = the receiver driving the bus, slave = the consumer.
interface uart_word_receiver_if;

  logic [7:0]  recv_byte_data;
  logic        recv_byte_done;
  logic [31:0] recv_4bytes_data;
  logic        recv_4bytes_done;
  logic        recv_4bytes_done_posedge;

  modport master (
    output recv_byte_data,
    output recv_byte_done,
    output recv_4bytes_data,
    output recv_4bytes_done,
    output recv_4bytes_done_posedge
  );

  modport slave (
    input recv_byte_data,
    input recv_byte_done,
    input recv_4bytes_data,
    input recv_4bytes_done,
    input recv_4bytes_done_posedge
  );

endinterface

// File: rtl/posedge_capturer.sv
// Registered rising-edge detector.
//   sys_clk        : clock, rising edge
//   sys_rst        : synchronous active-high reset
//   signal         : level to watch
//   signal_posedge : high for one cycle, one cycle after signal rises
module posedge_capturer (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic signal,
  output logic signal_posedge
);

  logic signal_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      signal_d       <= 1'b0;
      signal_posedge <= 1'b0;
    end else begin
      signal_d       <= signal;
      signal_posedge <= signal & ~signal_d;
    end
  end

endmodule

// File: rtl/uart_word_receiver.sv
// UART 8N1 receiver that also packs four consecutive bytes into a
// little-endian 32-bit word (first byte in bits [7:0]).
//   sys_clk  : clock, all logic on rising edge
//   sys_rst  : synchronous active-high reset
//   uart_rxd : asynchronous serial line, idle high
//   rx_bus   : result bus (byte data/strobe, word data/level/strobe)
module uart_word_receiver
  import uart_word_receiver_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT,
  parameter int unsigned UART_BPS = UART_BPS_DEFAULT
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   uart_rxd,
  uart_word_receiver_if.master   rx_bus
);

  localparam int unsigned BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned CNT_W   = $clog2(BPS_CNT);

  // Synchronizer (s1, s2) plus history flop (s3) for falling-edge detect.
  logic rxd_s1, rxd_s2, rxd_s3;
  logic rxd_fall;

  rx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             baud_mid;
  logic             baud_end;

  logic [1:0]       byte_idx;
  logic             done_posedge;

  assign rxd_fall = rxd_s3 & ~rxd_s2;
  assign baud_mid = (baud_cnt == CNT_W'(BPS_CNT / 2));
  assign baud_end = (baud_cnt == CNT_W'(BPS_CNT - 1));

  // Byte receiver. The counter is cleared on every exit to idle so that a
  // start edge seen in the very first idle cycle begins a clean bit period.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rxd_s1                <= 1'b1;
      rxd_s2                <= 1'b1;
      rxd_s3                <= 1'b1;
      state                 <= RX_IDLE;
      baud_cnt              <= '0;
      bit_cnt               <= '0;
      shift_reg             <= '0;
      rx_bus.recv_byte_data <= '0;
      rx_bus.recv_byte_done <= 1'b0;
    end else begin
      rxd_s1                <= uart_rxd;
      rxd_s2                <= rxd_s1;
      rxd_s3                <= rxd_s2;
      rx_bus.recv_byte_done <= 1'b0;

      case (state)
        RX_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (rxd_fall) state <= RX_START;
        end

        RX_START: begin
          baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
          if (baud_mid && rxd_s2) begin
            // Start bit high at mid-bit: treat as a glitch.
            state    <= RX_IDLE;
            baud_cnt <= '0;
          end else if (baud_end) begin
            state <= RX_DATA;
          end
        end

        RX_DATA: begin
          baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
          if (baud_mid) shift_reg[bit_cnt] <= rxd_s2;
          if (baud_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end
        end

        RX_STOP: begin
          baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
          // Return to idle at mid-stop so a back-to-back start edge is caught.
          if (baud_mid) begin
            state    <= RX_IDLE;
            baud_cnt <= '0;
            if (rxd_s2) begin
              rx_bus.recv_byte_data <= shift_reg;
              rx_bus.recv_byte_done <= 1'b1;
            end
          end
        end

        default: begin
          state    <= RX_IDLE;
          baud_cnt <= '0;
        end
      endcase
    end
  end

  // Word packer: partial words are visible; the done level clears on the
  // first byte of the next word.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_bus.recv_4bytes_data <= '0;
      rx_bus.recv_4bytes_done <= 1'b0;
      byte_idx                <= '0;
    end else if (rx_bus.recv_byte_done) begin
      rx_bus.recv_4bytes_data[{byte_idx, 3'b000} +: 8] <= rx_bus.recv_byte_data;
      rx_bus.recv_4bytes_done <= (byte_idx == 2'd3);
      byte_idx                <= byte_idx + 1'b1;
    end
  end

  posedge_capturer u_done_posedge (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .signal         (rx_bus.recv_4bytes_done),
    .signal_posedge (done_posedge)
  );

  assign rx_bus.recv_4bytes_done_posedge = done_posedge;

endmodule

// File: tb/tb_uart_word_receiver.sv
// Directed bench for uart_word_receiver with hand-computed expectations.
// The clock is scaled so one bit is 250 cycles at 115200 baud.
module tb_uart_word_receiver;

  localparam int unsigned CLK_FREQ = 28_800_000;
  localparam int unsigned UART_BPS = 115200;
  localparam int unsigned BPS      = 250;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;

  always #10 clk = ~clk;

  uart_word_receiver_if rx_if ();

  uart_word_receiver #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .uart_rxd (rxd),
    .rx_bus   (rx_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe monitor, sampled on the falling edge.
  int cyc       = 0;
  int byte_cnt  = 0;
  int pos_cnt   = 0;
  int bd_run    = 0;
  int bd_max    = 0;
  int pos_run   = 0;
  int pos_max   = 0;
  int rise_cyc  = 0;
  int pos_gap   = -1;
  logic done_prev = 1'b0;
  logic pos_prev  = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_if.recv_byte_done === 1'b1) begin
      bd_run = bd_run + 1;
      if (bd_run == 1) byte_cnt = byte_cnt + 1;
    end else begin
      bd_run = 0;
    end
    if (bd_run > bd_max) bd_max = bd_run;
    if (rx_if.recv_4bytes_done === 1'b1 && done_prev !== 1'b1) rise_cyc = cyc;
    if (rx_if.recv_4bytes_done_posedge === 1'b1) begin
      pos_run = pos_run + 1;
      if (pos_prev !== 1'b1) begin
        pos_cnt = pos_cnt + 1;
        pos_gap = cyc - rise_cyc;
      end
    end else begin
      pos_run = 0;
    end
    if (pos_run > pos_max) pos_max = pos_run;
    done_prev = rx_if.recv_4bytes_done;
    pos_prev  = rx_if.recv_4bytes_done_posedge;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (BPS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BPS) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BPS) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0;
    int p0;

    rst = 1'b1;
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_byte_data",  32'(rx_if.recv_byte_data), 32'h0);
    check_eq("rst_byte_done",  32'(rx_if.recv_byte_done), 32'h0);
    check_eq("rst_word_data",  rx_if.recv_4bytes_data, 32'h0);
    check_eq("rst_word_done",  32'(rx_if.recv_4bytes_done), 32'h0);
    check_eq("rst_word_pos",   32'(rx_if.recv_4bytes_done_posedge), 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single byte
    b0 = byte_cnt;
    send_byte(8'hA5, 1'b1);
    check_eq("a5_strobes",    32'(byte_cnt - b0), 32'd1);
    check_eq("a5_byte_data",  32'(rx_if.recv_byte_data), 32'hA5);
    check_eq("a5_word_done",  32'(rx_if.recv_4bytes_done), 32'h0);
    check_eq("a5_word_data",  rx_if.recv_4bytes_data, 32'h0000_00A5);

    // Full word, realigned by reset
    pulse_reset();
    check_eq("rst2_word_data", rx_if.recv_4bytes_data, 32'h0);
    p0 = pos_cnt;
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    check_eq("w1_partial",      rx_if.recv_4bytes_data, 32'h0000_5678);
    check_eq("w1_partial_done", 32'(rx_if.recv_4bytes_done), 32'h0);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    check_eq("w1_data",   rx_if.recv_4bytes_data, 32'h1234_5678);
    check_eq("w1_done",   32'(rx_if.recv_4bytes_done), 32'h1);
    check_eq("w1_pos_n",  32'(pos_cnt - p0), 32'd1);
    check_eq("w1_pos_gap", 32'(pos_gap), 32'd1);

    // Start-bit glitch
    b0 = byte_cnt;
    rxd = 1'b0;
    repeat (100) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * BPS) @(negedge clk);
    check_eq("glitch_strobes", 32'(byte_cnt - b0), 32'd0);

    // Framing error
    send_byte(8'h3C, 1'b0);
    repeat (BPS) @(negedge clk);
    check_eq("frame_strobes",   32'(byte_cnt - b0), 32'd0);
    check_eq("frame_byte_data", 32'(rx_if.recv_byte_data), 32'h12);

    // Back-to-back words; first byte lands in index 0 (index unchanged)
    p0 = pos_cnt;
    send_byte(8'h44, 1'b1);
    check_eq("w2_first_clear", 32'(rx_if.recv_4bytes_done), 32'h0);
    check_eq("w2_first_data",  rx_if.recv_4bytes_data, 32'h1234_5644);
    send_byte(8'h33, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h11, 1'b1);
    check_eq("w2_data", rx_if.recv_4bytes_data, 32'h1122_3344);
    check_eq("w2_done", 32'(rx_if.recv_4bytes_done), 32'h1);
    send_byte(8'hEF, 1'b1);
    check_eq("w3_first_clear", 32'(rx_if.recv_4bytes_done), 32'h0);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    check_eq("w3_data",  rx_if.recv_4bytes_data, 32'hDEAD_BEEF);
    check_eq("w3_done",  32'(rx_if.recv_4bytes_done), 32'h1);
    check_eq("w23_pos_n", 32'(pos_cnt - p0), 32'd2);

    // Reset after two bytes and in the middle of a third frame
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    check_eq("part_data", rx_if.recv_4bytes_data, 32'hDEAD_BBAA);
    check_eq("part_done", 32'(rx_if.recv_4bytes_done), 32'h0);
    rxd = 1'b0;
    repeat (3 * BPS) @(negedge clk);
    rxd = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midrst_word_data", rx_if.recv_4bytes_data, 32'h0);
    check_eq("midrst_byte_data", 32'(rx_if.recv_byte_data), 32'h0);
    rst = 1'b0;
    repeat (2 * BPS) @(negedge clk);
    p0 = pos_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    check_eq("w4_data",  rx_if.recv_4bytes_data, 32'h0403_0201);
    check_eq("w4_done",  32'(rx_if.recv_4bytes_done), 32'h1);
    check_eq("w4_pos_n", 32'(pos_cnt - p0), 32'd1);

    check_eq("byte_done_width", 32'(bd_max), 32'd1);
    check_eq("pos_width",       32'(pos_max), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
